fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Small instruction buffer directly downstream of the program-counter/instruction-ROM fetch stage.
- Captures each fetched {PC, instruction} pair and holds it until the decode stage accepts it.
- Decouples fetch from decode stalls through a valid/ready handshake on both sides.
- Discards all buffered entries on a flush, e.g. a taken branch that loads the PC from the immediate path.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; asserting it (0) clears the queue immediately, and release is synchronous to clk.
- flush  input  1  discard all entries; takes effect at the next rising edge.
- in_valid  input  1  fetch stage presents a valid pair.
- in_ready  output  1  queue can accept a pair this cycle.
- in_pc  input  ADDR_WIDTH  PC of the presented instruction.
- in_instr  input  DATA_WIDTH  instruction word from ROM.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  ADDR_WIDTH  PC of the head entry.
- out_instr  output  DATA_WIDTH  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  number of stored entries.

Behaviour:
- Reset (rst=0): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=1, out_pc=0, out_instr=NOP (0x00000013). Storage contents are don't-care.
- Handshakes:
  - Push occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - Inputs are sampled only on a handshake.
- Flow control:
  - in_ready = (count != DEPTH) && !flush. It does not depend on out_ready, so there is no combinational ready path.
  - out_valid = (count != 0) && !flush.
- Data path:
  - out_pc and out_instr are driven combinationally from the entry at rd_ptr when count != 0.
  - When empty, outputs are 0 and NOP.
- Latency: a pair pushed at edge N is visible on out_* after edge N; there is no same-cycle fall-through when empty.
- Pointers: wrap modulo DEPTH, with log2(DEPTH) bits each; count tracks occupancy explicitly.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal at any occupancy 1..DEPTH-1. At count=DEPTH push is blocked; at count=0 pop is blocked.
- Full: in_ready=0; in_valid is ignored and the upstream PC must hold.
- Empty: out_valid=0; out_ready is ignored.
- Flush:
  - At the next edge, rd_ptr=wr_ptr=0 and count=0.
  - During the flush cycle, in_ready=0 and out_valid=0, so no push or pop occurs.
  - Flush has priority over every other event.
  - Flush held for several cycles keeps the queue empty.
- Reset mid-operation: all entries are lost immediately, regardless of the clock.
- Ordering: strict FIFO; no entry is duplicated or reordered.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t packed struct {pc [ADDR_WIDTH-1:0], instr [DATA_WIDTH-1:0]}.
  - localparam NOP_INSTR = 32'h00000013.
  - localparam RESET_PC = 32'h0.
- Sub-module fetch_queue_mem: DEPTH x fetch_entry_t register array with synchronous write port (we, waddr, wdata) and combinational read port (raddr, rdata); no reset on the array.
- Top level holds pointers, count, handshake and flush logic.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then release -> count=0, out_valid=0, in_ready=1, out_instr=0x00000013.
- Fill to full: push (0x0,0xA1),(0x4,0xA2),(0x8,0xA3),(0xC,0xA4) with out_ready=0 -> count=4, in_ready=0. A fifth push of (0x10,0xA5) is not accepted. Then drain with out_ready=1 -> out_pc 0x0,0x4,0x8,0xC in order.
- Concurrent push/pop: at count=2, hold in_valid=1 and out_ready=1 for 6 cycles -> count stays 2 and output order matches input order. Also wrap pointers past DEPTH to confirm correct wrap.
- Flush with traffic: count=3, flush=1 with in_valid=1 and out_ready=1 -> no handshake that cycle; next cycle count=0, out_valid=0. A push of (0x40,0xB1) afterwards appears at the head one cycle later.
- Async reset mid-stream: count=3, drive rst=0 between clock edges -> count=0 and out_valid=0 before the next rising edge. After release, in_ready=1.
- Random back-pressure: 1000 cycles of random in_valid/out_ready against a scoreboard model -> zero mismatches, and count never exceeds 4.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: the stored {PC, instruction}
// entry and the values presented when the queue is empty.
package fetch_pkg;

    localparam int FQ_ADDR_WIDTH = 32;
    localparam int FQ_DATA_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [FQ_ADDR_WIDTH-1:0] pc;
        logic [FQ_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch (push side) and decode (pop side).
// The queue connects through the slave modport; the surrounding stages
// (or a testbench) drive through the master modport.
interface fetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_instr;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_instr;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, combinational read.
// The array is intentionally not reset; occupancy is tracked by the top level.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  fetch_entry_t       wdata,
    input  logic [PTR_W-1:0]   raddr,
    output fetch_entry_t       rdata
);

    fetch_entry_t mem_q [DEPTH];

    // Write port: store the pushed pair at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer. Holds {PC, instruction} pairs in strict
// FIFO order, decouples the two stages with valid/ready, and drops everything
// on flush. in_ready depends only on occupancy and flush, never on out_ready.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = FQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = FQ_DATA_WIDTH,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    fetch_queue_if.slave     bus,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             in_ready_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;
    fetch_entry_t     wdata_s;
    fetch_entry_t     rdata_s;
    logic [ADDR_WIDTH-1:0] out_pc_s;
    logic [DATA_WIDTH-1:0] out_instr_s;

    assign wdata_s = '{pc: bus.in_pc, instr: bus.in_instr};

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_q),
        .wdata (wdata_s),
        .raddr (rd_ptr_q),
        .rdata (rdata_s)
    );

    // Handshake qualification: flush masks both sides for the cycle it is high.
    always_comb begin
        in_ready_s  = (count_q != CNT_W'(DEPTH)) && !flush;
        out_valid_s = (count_q != CNT_W'(0)) && !flush;
        push_s      = bus.in_valid && in_ready_s;
        pop_s       = out_valid_s && bus.out_ready;
    end

    // Next-state for pointers and occupancy; flush overrides everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = PTR_W'(0);
            wr_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset clears the queue immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= PTR_W'(0);
            wr_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head presentation: show the entry at rd_ptr, or PC 0 / NOP when empty.
    always_comb begin
        if (count_q != CNT_W'(0)) begin
            out_pc_s    = rdata_s.pc;
            out_instr_s = rdata_s.instr;
        end else begin
            out_pc_s    = ADDR_WIDTH'(RESET_PC);
            out_instr_s = DATA_WIDTH'(NOP_INSTR);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_pc    = out_pc_s;
    assign bus.out_instr = out_instr_s;
    assign count         = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and scoreboard-checked bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    fetch_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) fq_if ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (fq_if),
        .count (count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ordy;
        logic [2:0]  ecnt;
        logic        eov;
        logic        eir;
        logic [31:0] epc;
        logic [31:0] eins;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        fq_if.in_valid  = 1'b0;
        fq_if.in_pc     = 32'h0;
        fq_if.in_instr  = 32'h0;
        fq_if.out_ready = 1'b0;
        flush           = 1'b0;
    endtask

    // Advance one clock, landing 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
        fq_if.in_valid = 1'b1;
        fq_if.in_pc    = pc;
        fq_if.in_instr = ins;
        tick();
        idle();
    endtask

    task automatic check_state(input string tag, input logic [2:0] ecnt, input logic eov,
                               input logic eir, input logic [31:0] epc, input logic [31:0] eins);
        check({tag, " count"},     64'(count),           64'(ecnt));
        check({tag, " out_valid"}, 64'(fq_if.out_valid), 64'(eov));
        check({tag, " in_ready"},  64'(fq_if.in_ready),  64'(eir));
        check({tag, " out_pc"},    64'(fq_if.out_pc),    64'(epc));
        check({tag, " out_instr"}, 64'(fq_if.out_instr), 64'(eins));
    endtask

    logic [31:0] model_pc[$];
    logic [31:0] model_ins[$];

    initial begin
        idle();

        // Reset held for two cycles, then released just after an edge.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("in_reset", 3'd0, 1'b0, 1'b1, 32'h0, NOP);
        rst = 1'b1;
        tick();
        check_state("reset_idle", 3'd0, 1'b0, 1'b1, 32'h0, NOP);

        // Fill, overfill attempt, drain, then concurrent push/pop with pointer wrap.
        vecs.push_back('{1'b1, 32'h00, 32'hA1, 1'b0, 3'd1, 1'b1, 1'b1, 32'h00, 32'hA1});
        vecs.push_back('{1'b1, 32'h04, 32'hA2, 1'b0, 3'd2, 1'b1, 1'b1, 32'h00, 32'hA1});
        vecs.push_back('{1'b1, 32'h08, 32'hA3, 1'b0, 3'd3, 1'b1, 1'b1, 32'h00, 32'hA1});
        vecs.push_back('{1'b1, 32'h0C, 32'hA4, 1'b0, 3'd4, 1'b1, 1'b0, 32'h00, 32'hA1});
        vecs.push_back('{1'b1, 32'h10, 32'hA5, 1'b0, 3'd4, 1'b1, 1'b0, 32'h00, 32'hA1});
        vecs.push_back('{1'b0, 32'h00, 32'h00, 1'b1, 3'd3, 1'b1, 1'b1, 32'h04, 32'hA2});
        vecs.push_back('{1'b0, 32'h00, 32'h00, 1'b1, 3'd2, 1'b1, 1'b1, 32'h08, 32'hA3});
        vecs.push_back('{1'b0, 32'h00, 32'h00, 1'b1, 3'd1, 1'b1, 1'b1, 32'h0C, 32'hA4});
        vecs.push_back('{1'b0, 32'h00, 32'h00, 1'b1, 3'd0, 1'b0, 1'b1, 32'h00, NOP});
        vecs.push_back('{1'b0, 32'h00, 32'h00, 1'b1, 3'd0, 1'b0, 1'b1, 32'h00, NOP});
        vecs.push_back('{1'b1, 32'h20, 32'hC1, 1'b0, 3'd1, 1'b1, 1'b1, 32'h20, 32'hC1});
        vecs.push_back('{1'b1, 32'h24, 32'hC2, 1'b0, 3'd2, 1'b1, 1'b1, 32'h20, 32'hC1});
        vecs.push_back('{1'b1, 32'h28, 32'hC3, 1'b1, 3'd2, 1'b1, 1'b1, 32'h24, 32'hC2});
        vecs.push_back('{1'b1, 32'h2C, 32'hC4, 1'b1, 3'd2, 1'b1, 1'b1, 32'h28, 32'hC3});
        vecs.push_back('{1'b1, 32'h30, 32'hC5, 1'b1, 3'd2, 1'b1, 1'b1, 32'h2C, 32'hC4});
        vecs.push_back('{1'b1, 32'h34, 32'hC6, 1'b1, 3'd2, 1'b1, 1'b1, 32'h30, 32'hC5});
        vecs.push_back('{1'b1, 32'h38, 32'hC7, 1'b1, 3'd2, 1'b1, 1'b1, 32'h34, 32'hC6});
        vecs.push_back('{1'b1, 32'h3C, 32'hC8, 1'b1, 3'd2, 1'b1, 1'b1, 32'h38, 32'hC7});
        vecs.push_back('{1'b1, 32'h50, 32'hD1, 1'b0, 3'd3, 1'b1, 1'b1, 32'h38, 32'hC7});

        for (int i = 0; i < vecs.size(); i++) begin
            fq_if.in_valid  = vecs[i].iv;
            fq_if.in_pc     = vecs[i].pc;
            fq_if.in_instr  = vecs[i].ins;
            fq_if.out_ready = vecs[i].ordy;
            tick();
            idle();
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].eov,
                        vecs[i].eir, vecs[i].epc, vecs[i].eins);
        end

        // Flush with traffic at count=3: no handshake that cycle.
        flush           = 1'b1;
        fq_if.in_valid  = 1'b1;
        fq_if.in_pc     = 32'h60;
        fq_if.in_instr  = 32'hE1;
        fq_if.out_ready = 1'b1;
        #1;
        check("flush_cycle in_ready",  64'(fq_if.in_ready),  64'd0);
        check("flush_cycle out_valid", 64'(fq_if.out_valid), 64'd0);
        tick();
        idle();
        #1;
        check_state("after_flush", 3'd0, 1'b0, 1'b1, 32'h0, NOP);
        push_one(32'h40, 32'hB1);
        check_state("post_flush_push", 3'd1, 1'b1, 1'b1, 32'h40, 32'hB1);

        // Flush held for three cycles while fetch keeps presenting.
        for (int i = 0; i < 3; i++) begin
            flush           = 1'b1;
            fq_if.in_valid  = 1'b1;
            fq_if.in_pc     = 32'h70 + 32'(i);
            fq_if.in_instr  = 32'hF0;
            fq_if.out_ready = 1'b1;
            tick();
            check($sformatf("flush_hold%0d count", i), 64'(count), 64'd0);
        end
        idle();
        #1;
        check_state("flush_hold_end", 3'd0, 1'b0, 1'b1, 32'h0, NOP);

        // Asynchronous reset between edges at count=3.
        push_one(32'h80, 32'h81);
        push_one(32'h84, 32'h85);
        push_one(32'h88, 32'h89);
        check("pre_reset count", 64'(count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset count",     64'(count),           64'd0);
        check("async_reset out_valid", 64'(fq_if.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_state("after_async_reset", 3'd0, 1'b0, 1'b1, 32'h0, NOP);

        // Random back-pressure against a queue model.
        model_pc.delete();
        model_ins.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            logic exp_ir, exp_ov, do_push, do_pop;
            fq_if.in_valid  = 1'($urandom_range(0, 1));
            fq_if.out_ready = 1'($urandom_range(0, 1));
            fq_if.in_pc     = 32'h1000 + 32'(cyc * 4);
            fq_if.in_instr  = 32'hAB00_0000 ^ 32'(cyc);
            #1;
            exp_ir = (model_pc.size() != DEPTH);
            exp_ov = (model_pc.size() != 0);
            check("rnd in_ready",  64'(fq_if.in_ready),  64'(exp_ir));
            check("rnd out_valid", 64'(fq_if.out_valid), 64'(exp_ov));
            check("rnd count",     64'(count),           64'(model_pc.size()));
            if (exp_ov) begin
                check("rnd out_pc",    64'(fq_if.out_pc),    64'(model_pc[0]));
                check("rnd out_instr", 64'(fq_if.out_instr), 64'(model_ins[0]));
            end else begin
                check("rnd empty_instr", 64'(fq_if.out_instr), 64'(NOP));
            end
            do_push = fq_if.in_valid && exp_ir;
            do_pop  = fq_if.out_ready && exp_ov;
            if (do_pop) begin
                void'(model_pc.pop_front());
                void'(model_ins.pop_front());
            end
            if (do_push) begin
                model_pc.push_back(fq_if.in_pc);
                model_ins.push_back(fq_if.in_instr);
            end
            tick();
            if (count > 3'd4) begin
                n_tests++;
                n_fail++;
                $display("FAIL rnd count_bound: got %0d required <= 4", count);
            end
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
